// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// FSM state encoding and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Returns 1 for misaligned accesses and for funct3 codes that are not a
  // legal load (000/001/010/100/101) or legal store (000/001/010).
  function automatic logic req_is_error(input logic       store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = offset[0];
      F3_W:    err = (offset != 2'b00);
      F3_BU:   err = store;
      F3_HU:   err = store | offset[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus data-RAM bus of the load/store unit.
// slave = the unit itself, master = the core and RAM around it.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_error;

  logic [ADDR_W-1:0] ram_adress;
  logic [31:0]       data_in_ram;
  logic [31:0]       data_out_ram;
  logic              ram_enable_write;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_error,
    input  resp_ready,
    output ram_adress, data_out_ram, ram_enable_write,
    input  data_in_ram
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_error,
    output resp_ready,
    input  ram_adress, data_out_ram, ram_enable_write,
    output data_in_ram
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: extracts and extends load data from a RAM
// word, and merges sub-word store data into a RAM word (little-endian).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes of the RAM word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Sign/zero-extend the selected lane according to the load width
  always_comb begin
    o_rdata = i_word;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = i_word;
    endcase
  end

  // Overlay the store lane onto the previously read word (read-modify-write)
  always_comb begin
    o_wword = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_wword = i_word;
        case (i_offset)
          2'd0: o_wword[7:0]   = i_wdata[7:0];
          2'd1: o_wword[15:8]  = i_wdata[7:0];
          2'd2: o_wword[23:16] = i_wdata[7:0];
          2'd3: o_wword[31:24] = i_wdata[7:0];
          default: o_wword = i_word;
        endcase
      end
      F3_H: begin
        o_wword = i_word;
        if (i_offset[1]) o_wword[31:16] = i_wdata[15:0];
        else             o_wword[15:0]  = i_wdata[15:0];
      end
      default: o_wword = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time from the execute
// stage, drives a word-wide data RAM (read-modify-write for SB/SH) and
// returns a held response with extended load data or an error flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int LAST  = READ_LATENCY - 1;

  lsu_state_t        r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  // Latched request (datapath only, no reset needed)
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic              r_store;

  // Registered outputs and their next values
  logic [ADDR_W-1:0] r_ram_adress, w_ram_adress;
  logic [31:0]       r_data_out,   w_data_out;
  logic              r_we,         w_we;
  logic              r_resp_valid, w_resp_valid;
  logic [31:0]       r_resp_rdata, w_resp_rdata;
  logic [4:0]        r_resp_rd,    w_resp_rd;
  logic              r_resp_error, w_resp_error;

  logic              w_accept;
  logic              w_req_err;
  logic              w_last_read;
  logic [31:0]       w_rdata;
  logic [31:0]       w_wword;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_req_err   = req_is_error(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
  assign w_last_read = (r_cnt == CNT_W'(LAST));

  lsu_lane u_lane (
    .i_word   (bus.data_in_ram),
    .i_wdata  (r_wdata),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_rdata  (w_rdata),
    .o_wword  (w_wword)
  );

  // Capture the request fields at the handshake
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr   <= bus.req_addr;
      r_funct3 <= bus.req_funct3;
      r_wdata  <= bus.req_wdata;
      r_rd     <= bus.req_rd;
      r_store  <= bus.req_store;
    end
  end

  // State, latency counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ram_adress <= '0;
      r_data_out   <= '0;
      r_we         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_ram_adress <= w_ram_adress;
      r_data_out   <= w_data_out;
      r_we         <= w_we;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_rd    <= w_resp_rd;
      r_resp_error <= w_resp_error;
    end
  end

  // Next-state and next-output logic; outputs hold unless a transition updates them
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_ram_adress = r_ram_adress;
    w_data_out   = r_data_out;
    w_we         = 1'b0;
    w_resp_valid = r_resp_valid;
    w_resp_rdata = r_resp_rdata;
    w_resp_rd    = r_resp_rd;
    w_resp_error = r_resp_error;

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err) begin
            // Illegal or misaligned: answer straight away, never touch RAM
            w_state      = ST_RESP;
            w_resp_valid = 1'b1;
            w_resp_error = 1'b1;
            w_resp_rdata = '0;
            w_resp_rd    = bus.req_rd;
          end else if (bus.req_store && (bus.req_funct3 == F3_W)) begin
            // Full-word store needs no read
            w_state      = ST_WRITE;
            w_ram_adress = {2'b00, bus.req_addr[ADDR_W-1:2]};
            w_data_out   = bus.req_wdata;
            w_we         = 1'b1;
          end else begin
            w_state      = ST_READ;
            w_ram_adress = {2'b00, bus.req_addr[ADDR_W-1:2]};
            w_cnt        = '0;
          end
        end
      end

      ST_READ: begin
        if (w_last_read) begin
          if (r_store) begin
            w_state    = ST_WRITE;
            w_data_out = w_wword;
            w_we       = 1'b1;
          end else begin
            w_state      = ST_RESP;
            w_resp_valid = 1'b1;
            w_resp_error = 1'b0;
            w_resp_rdata = w_rdata;
            w_resp_rd    = r_rd;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_WRITE: begin
        w_state      = ST_RESP;
        w_resp_valid = 1'b1;
        w_resp_error = 1'b0;
        w_resp_rdata = '0;
        w_resp_rd    = r_rd;
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          w_state      = ST_IDLE;
          w_resp_valid = 1'b0;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.req_ready        = (r_state == ST_IDLE);
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_rdata       = r_resp_rdata;
  assign bus.resp_rd          = r_resp_rd;
  assign bus.resp_error       = r_resp_error;
  assign bus.ram_adress       = r_ram_adress;
  assign bus.data_out_ram     = r_data_out;
  assign bus.ram_enable_write = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with READ_LATENCY=1 on a
// small word RAM model, a second with READ_LATENCY=3 sharing the RAM.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus1 ();
  lsu_if #(.ADDR_W(32)) bus3 ();

  load_store_unit #(.READ_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));
  load_store_unit #(.READ_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave));

  // RAM model: combinational read with the address held for the whole READ phase
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          we_count = 0;

  assign bus1.data_in_ram = mem[bus1.ram_adress[3:0]];
  assign bus3.data_in_ram = mem[bus3.ram_adress[3:0]];

  // RAM writes: bench preload or DUT write strobe
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus1.ram_enable_write === 1'b1) mem[bus1.ram_adress[3:0]] <= bus1.data_out_ram;
  end

  // Count write strobes seen from the latency-1 instance
  always @(posedge clk) begin
    if (bus1.ram_enable_write === 1'b1) we_count <= we_count + 1;
  end

  int vectors = 0;
  int miscompares = 0;
  int we_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Present a request on bus1 one cycle; returns at cycle 1 + 1ns
  task automatic issue1(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    bus1.req_store = st; bus1.req_funct3 = f3; bus1.req_addr = a;
    bus1.req_wdata = wd; bus1.req_rd = rd; bus1.req_valid = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
  endtask

  // Response expected first in cycle lat (accept cycle = 0); ends at next cycle + 1ns
  task automatic expect1(input string tag, input int lat, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic err);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk({tag, ".early_valid"}, 32'(bus1.resp_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus1.resp_valid), 32'd1);
    chk({tag, ".rdata"}, bus1.resp_rdata, rdata);
    chk({tag, ".rd"},    32'(bus1.resp_rd), 32'(rd));
    chk({tag, ".error"}, 32'(bus1.resp_error), 32'(err));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_store = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_rd = '0; bus1.resp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_store = 1'b0; bus3.req_funct3 = '0;
    bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_rd = '0; bus3.resp_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst.req_ready",  32'(bus1.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus1.resp_valid), 32'd0);
    chk("rst.resp_rdata", bus1.resp_rdata, 32'd0);
    chk("rst.resp_rd",    32'(bus1.resp_rd), 32'd0);
    chk("rst.resp_error", 32'(bus1.resp_error), 32'd0);
    chk("rst.ram_adress", bus1.ram_adress, 32'd0);
    chk("rst.data_out",   bus1.data_out_ram, 32'd0);
    chk("rst.we",         32'(bus1.ram_enable_write), 32'd0);

    @(posedge clk); #1;
    preload(4'd4, 32'h8877_66F0);
    preload(4'd5, 32'hAABB_CCDD);
    preload(4'd7, 32'hCAFE_BABE);
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte loads, sign and zero extended
    issue1(1'b0, F3_B, 32'h10, 32'd0, 5'd3);
    expect1("lb", 2, 32'hFFFF_FFF0, 5'd3, 1'b0);
    issue1(1'b0, F3_BU, 32'h10, 32'd0, 5'd4);
    expect1("lbu", 2, 32'h0000_00F0, 5'd4, 1'b0);

    // Upper-half loads
    issue1(1'b0, F3_H, 32'h12, 32'd0, 5'd6);
    expect1("lh", 2, 32'hFFFF_8877, 5'd6, 1'b0);
    issue1(1'b0, F3_HU, 32'h12, 32'd0, 5'd7);
    expect1("lhu", 2, 32'h0000_8877, 5'd7, 1'b0);
    chk("loads.no_write", 32'(we_count), 32'd0);

    // Byte store with read-modify-write
    issue1(1'b1, F3_B, 32'h15, 32'h0000_0011, 5'd1);
    @(negedge clk);
    chk("sb.c1_we", 32'(bus1.ram_enable_write), 32'd0);
    @(negedge clk);
    chk("sb.c2_we",       32'(bus1.ram_enable_write), 32'd1);
    chk("sb.c2_adress",   bus1.ram_adress, 32'd5);
    chk("sb.c2_data_out", bus1.data_out_ram, 32'hAABB_11DD);
    @(negedge clk);
    chk("sb.c3_we",    32'(bus1.ram_enable_write), 32'd0);
    chk("sb.c3_valid", 32'(bus1.resp_valid), 32'd1);
    chk("sb.c3_rdata", bus1.resp_rdata, 32'd0);
    chk("sb.c3_rd",    32'(bus1.resp_rd), 32'd1);
    @(posedge clk); #1;
    chk("sb.mem5",     mem[5], 32'hAABB_11DD);
    chk("sb.we_count", 32'(we_count), 32'd1);

    // Aligned word store: write in cycle 1, response in cycle 2
    issue1(1'b1, F3_W, 32'h18, 32'h1234_5678, 5'd2);
    @(negedge clk);
    chk("sw.c1_we",       32'(bus1.ram_enable_write), 32'd1);
    chk("sw.c1_adress",   bus1.ram_adress, 32'd6);
    chk("sw.c1_data_out", bus1.data_out_ram, 32'h1234_5678);
    @(negedge clk);
    chk("sw.c2_valid", 32'(bus1.resp_valid), 32'd1);
    chk("sw.c2_error", 32'(bus1.resp_error), 32'd0);
    @(posedge clk); #1;
    chk("sw.mem6", mem[6], 32'h1234_5678);

    // Halfword store into upper lane
    issue1(1'b1, F3_H, 32'h16, 32'h0000_BEEF, 5'd8);
    @(negedge clk);
    @(negedge clk);
    chk("sh.c2_data_out", bus1.data_out_ram, 32'hBEEF_11DD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sh.mem5", mem[5], 32'hBEEF_11DD);

    // Error cases: response in cycle 1, no strobe
    we_before = we_count;
    issue1(1'b1, F3_W, 32'h1A, 32'h1234_5678, 5'd10);
    expect1("sw_mis", 1, 32'd0, 5'd10, 1'b1);
    issue1(1'b0, F3_H, 32'h11, 32'd0, 5'd11);
    expect1("lh_mis", 1, 32'd0, 5'd11, 1'b1);
    issue1(1'b0, 3'b011, 32'h10, 32'd0, 5'd12);
    expect1("ld_f3_011", 1, 32'd0, 5'd12, 1'b1);
    issue1(1'b1, F3_BU, 32'h10, 32'h55, 5'd13);
    expect1("st_f3_100", 1, 32'd0, 5'd13, 1'b1);
    chk("err.no_write", 32'(we_count), 32'(we_before));
    chk("err.mem4",     mem[4], 32'h8877_66F0);

    // Back-pressure: LW held 4 cycles, second request waits
    bus1.resp_ready = 1'b0;
    issue1(1'b0, F3_W, 32'h10, 32'd0, 5'd5);
    @(negedge clk);
    chk("bp.c1_valid", 32'(bus1.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus1.req_store = 1'b0; bus1.req_funct3 = F3_BU; bus1.req_addr = 32'h10;
    bus1.req_rd = 5'd9; bus1.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp.hold_valid", 32'(bus1.resp_valid), 32'd1);
      chk("bp.hold_rdata", bus1.resp_rdata, 32'h8877_66F0);
      chk("bp.hold_rd",    32'(bus1.resp_rd), 32'd5);
      chk("bp.hold_ready", 32'(bus1.req_ready), 32'd0);
      if (k < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus1.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp.c6_valid", 32'(bus1.resp_valid), 32'd1);
    chk("bp.c6_ready", 32'(bus1.req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.c7_ready", 32'(bus1.req_ready), 32'd1);
    chk("bp.c7_valid", 32'(bus1.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    expect1("bp.second", 2, 32'h0000_00F0, 5'd9, 1'b0);

    // Reset asserted during the WRITE cycle of an SB
    we_before = we_count;
    issue1(1'b1, F3_B, 32'h1C, 32'h0000_0055, 5'd14);
    @(negedge clk);
    @(negedge clk);
    chk("rstw.pre_we", 32'(bus1.ram_enable_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw.we",         32'(bus1.ram_enable_write), 32'd0);
    chk("rstw.req_ready",  32'(bus1.req_ready), 32'd1);
    chk("rstw.resp_valid", 32'(bus1.resp_valid), 32'd0);
    chk("rstw.ram_adress", bus1.ram_adress, 32'd0);
    chk("rstw.data_out",   bus1.data_out_ram, 32'd0);
    chk("rstw.resp_rd",    32'(bus1.resp_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw.mem7",      mem[7], 32'hCAFE_BABE);
    chk("rstw.no_write",  32'(we_count), 32'(we_before));
    chk("rstw.no_resp",   32'(bus1.resp_valid), 32'd0);
    @(posedge clk); #1;

    // READ_LATENCY=3 instance: LW response in cycle 4
    bus3.req_store = 1'b0; bus3.req_funct3 = F3_W; bus3.req_addr = 32'h10;
    bus3.req_rd = 5'd4; bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk("lat3.early_valid", 32'(bus3.resp_valid), 32'd0);
    end
    @(negedge clk);
    chk("lat3.valid", 32'(bus3.resp_valid), 32'd1);
    chk("lat3.rdata", bus3.resp_rdata, 32'h8877_66F0);
    chk("lat3.rd",    32'(bus3.resp_rd), 32'd4);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
